keypad_scanner: RTL

- Scans a 4x4 matrix keypad and sequences key-press debouncing into a single registered key code with a one-cycle valid strobe.
- Drives the column lines and samples the row lines, which pass through a two-flop synchronizer.
- Time-shares one debounce counter between press and release qualification, so only one key is tracked at a time.
- Sits between the keypad pins and the display/key-history logic; runs on the same fabric clock as the debouncer.

---
 rtl/keypad_pkg.sv | 39 +++
 rtl/sync_2ff.sv | 27 ++
 rtl/keypad_scanner.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, the column
// settle window and the row/column to hex key-code map.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam int SETTLE_CYCLES = 3;

  // Layout by row: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
  function automatic logic [3:0] key_map(input logic [1:0] row_idx,
                                         input logic [1:0] col_idx);
    logic [3:0] v;
    case ({row_idx, col_idx})
      4'h0:    v = 4'h1;
      4'h1:    v = 4'h2;
      4'h2:    v = 4'h3;
      4'h3:    v = 4'hA;
      4'h4:    v = 4'h4;
      4'h5:    v = 4'h5;
      4'h6:    v = 4'h6;
      4'h7:    v = 4'hB;
      4'h8:    v = 4'h7;
      4'h9:    v = 4'h8;
      4'hA:    v = 4'h9;
      4'hB:    v = 4'hC;
      4'hC:    v = 4'hE;
      4'hD:    v = 4'h0;
      4'hE:    v = 4'hF;
      default: v = 4'hD;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all-ones so
// idle pulled-up lines read as inactive straight out of reset.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates an active-low column strobe, debounces one key at
// a time with a shared counter and reports it as a key code plus valid strobe.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter logic [21:0] SCAN_DIVIDER     = 22'd48000,
  parameter logic [21:0] DEBOUNCE_DIVIDER = 22'd240000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held,
  output logic [1:0] dbg_state
);

  localparam logic [21:0] SETTLE_CNT = 22'(SETTLE_CYCLES);

  if (DEBOUNCE_DIVIDER < 22'd2) begin : g_bad_debounce
    $error("keypad_scanner: DEBOUNCE_DIVIDER must be at least 2");
  end
  if (SCAN_DIVIDER <= SETTLE_CNT + 22'd1) begin : g_bad_scan
    $error("keypad_scanner: SCAN_DIVIDER must exceed SETTLE_CYCLES+1");
  end

  state_t      r_state, w_state_nxt;
  logic [21:0] r_cnt, w_cnt_nxt;
  logic [1:0]  r_col_idx, w_col_nxt;
  logic [3:0]  r_pat, w_pat_nxt;
  logic [3:0]  r_key, w_key_nxt;
  logic        r_key_valid, w_valid_nxt;
  logic        r_key_held, w_held_nxt;
  logic [3:0]  w_rows_s;
  logic        w_one_low;
  logic [1:0]  w_row_idx;

  sync_2ff #(.WIDTH(4)) u_rows_sync (
    .clk   (clk),
    .rst_n (reset),
    .i_d   (rows),
    .o_q   (w_rows_s)
  );

  // Multi-key presses are rejected so the captured pattern names one row.
  assign w_one_low = $onehot(~w_rows_s);

  always_comb begin
    case (r_pat)
      4'b1110: w_row_idx = 2'd0;
      4'b1101: w_row_idx = 2'd1;
      4'b1011: w_row_idx = 2'd2;
      default: w_row_idx = 2'd3;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_col_nxt   = r_col_idx;
    w_pat_nxt   = r_pat;
    w_key_nxt   = r_key;
    w_valid_nxt = 1'b0;
    w_held_nxt  = r_key_held;
    case (r_state)
      SCAN: begin
        if (r_cnt >= SETTLE_CNT && w_one_low) begin
          w_pat_nxt   = w_rows_s;
          w_cnt_nxt   = '0;
          w_state_nxt = DEBOUNCE;
        end else if (r_cnt == SCAN_DIVIDER - 22'd1) begin
          w_cnt_nxt = '0;
          w_col_nxt = r_col_idx + 2'd1;
        end else begin
          w_cnt_nxt = r_cnt + 22'd1;
        end
      end
      DEBOUNCE: begin
        if (w_rows_s != r_pat) begin
          w_cnt_nxt   = '0;
          w_state_nxt = SCAN;
        end else if (r_cnt == DEBOUNCE_DIVIDER - 22'd1) begin
          w_key_nxt   = key_map(w_row_idx, r_col_idx);
          w_valid_nxt = 1'b1;
          w_held_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = HELD;
        end else begin
          w_cnt_nxt = r_cnt + 22'd1;
        end
      end
      HELD: begin
        if (w_rows_s == 4'b1111) begin
          w_cnt_nxt   = '0;
          w_state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        // Any low row, on this or a stray key, counts as still held.
        if (w_rows_s != 4'b1111) begin
          w_state_nxt = HELD;
        end else if (r_cnt == DEBOUNCE_DIVIDER - 22'd1) begin
          w_held_nxt  = 1'b0;
          w_col_nxt   = r_col_idx + 2'd1;
          w_cnt_nxt   = '0;
          w_state_nxt = SCAN;
        end else begin
          w_cnt_nxt = r_cnt + 22'd1;
        end
      end
      default: w_state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= SCAN;
      r_cnt       <= '0;
      r_col_idx   <= '0;
      r_pat       <= 4'b1111;
      r_key       <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_col_idx   <= w_col_nxt;
      r_pat       <= w_pat_nxt;
      r_key       <= w_key_nxt;
      r_key_valid <= w_valid_nxt;
      r_key_held  <= w_held_nxt;
    end
  end

  assign cols      = ~(4'b0001 << r_col_idx);
  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;
  assign dbg_state = r_state;

endmodule
